alu_multicycle: RTL and testbench

//  Execute stage downstream of the ALU decoder: consumes the 3-bit alu_control code plus two

---
 rtl/alu_multicycle.sv | 163 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with a start/busy/done handshake.
// add/sub/slt finish one cycle after start; mul runs a WIDTH-cycle signed
// shift-add multiplier on magnitudes with a final conditional negation.
// Optional feature macro: ALU_MUL_HI_EN adds the result_hi port, which carries
// the upper half of the signed product.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_MUL_HI_EN
  ,
  output logic [WIDTH-1:0] result_hi
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b101;

  state_e               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q;
  logic [CNT_W-1:0]     count_q;
  logic [2*WIDTH-1:0]   acc_q;     // partial-product accumulator
  logic [2*WIDTH-1:0]   mcand_q;   // |a|, shifted left once per iteration
  logic [WIDTH-1:0]     mplier_q;  // |b|, shifted right once per iteration
  logic                 sign_q;    // sign of the final product
`ifdef ALU_MUL_HI_EN
  logic [WIDTH-1:0]     result_hi_q;
`endif

  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_final;

  // Single-cycle operations, computed straight from the start-cycle operands.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    alu_res = src_a + src_b;
    case (alu_control)
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_res = src_a + src_b;
    endcase
  end

  // Operand magnitudes; the most negative value maps to 2**(WIDTH-1) as unsigned.
  always_comb begin
    mag_a = src_a[WIDTH-1] ? (~src_a + 1'b1) : src_a;
    mag_b = src_b[WIDTH-1] ? (~src_b + 1'b1) : src_b;
  end

  // One shift-add step, plus the sign-corrected product used on the last step.
  always_comb begin
    acc_d      = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod_final = sign_q ? (~acc_d + 1'b1) : acc_d;
  end

`ifndef ALU_MUL_HI_EN
  // Upper product half is computed identically in both builds but kept only with the hi port.
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod_final[2*WIDTH-1:WIDTH];
`endif

  // Control FSM with registered handshake outputs and the multiplier datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking <= so all registers update from pre-edge values.
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
`ifdef ALU_MUL_HI_EN
      result_hi_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (alu_control == OP_MUL) begin
              state_q  <= S_MUL;
              count_q  <= '0;
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, mag_a};
              mplier_q <= mag_b;
              sign_q   <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            end else begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
`ifdef ALU_MUL_HI_EN
              result_hi_q <= '0;
`endif
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH-1)) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= prod_final[WIDTH-1:0];
            zero_q   <= (prod_final[WIDTH-1:0] == '0);
`ifdef ALU_MUL_HI_EN
            result_hi_q <= prod_final[2*WIDTH-1:WIDTH];
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
`ifdef ALU_MUL_HI_EN
  assign result_hi = result_hi_q;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed cases plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_alu_multicycle;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    alu_control;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          zero;
`ifdef ALU_MUL_HI_EN
  logic [W-1:0]  result_hi;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zero        (zero)
`ifdef ALU_MUL_HI_EN
    ,
    .result_hi   (result_hi)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: signed 64-bit arithmetic straight from the operation definitions.
  function automatic void model(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] lo, output logic [W-1:0] hi);
    longint p;
    hi = '0;
    case (code)
      3'b100:  lo = a - b;
      3'b110:  lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        lo = p[31:0];
        hi = p[63:32];
      end
      default: lo = a + b;
    endcase
  endfunction

  // Launch one operation, wait (bounded) for done, check latency, hold, and outputs.
  // With scramble set, inputs churn and start pulses at N+5 and N+20 while busy.
  task automatic run_op(input string tag, input logic [2:0] code, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit scramble);
    logic [W-1:0] exp_lo, exp_hi, prev_res;
    int lat, exp_lat;
    bit busy_bad, hold_bad;
    model(code, a, b, exp_lo, exp_hi);
    exp_lat  = (code == 3'b101) ? W + 1 : 1;
    prev_res = result;
    busy_bad = 0;
    hold_bad = 0;
    @(negedge clk);
    start = 1'b1; alu_control = code; src_a = a; src_b = b;
    @(negedge clk);
    lat = 1;
    start = 1'b0;
    while (!done && lat < 60) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (result !== prev_res) hold_bad = 1;
      if (scramble) begin
        start       = (lat == 5 || lat == 20);
        src_a       = $urandom;
        src_b       = $urandom;
        alu_control = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, {62'd0, busy, busy_bad}, {62'd0, 1'b1, 1'b0});
    check({tag, "_hold"}, 64'(hold_bad), 64'd0);
    check({tag, "_result"}, 64'(result), 64'(exp_lo));
    check({tag, "_zero"}, 64'(zero), 64'(exp_lo == '0));
`ifdef ALU_MUL_HI_EN
    check({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
`endif
    @(negedge clk);
    check({tag, "_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [2:0] codes [8];
    logic [W-1:0] corner [4];
    logic [W-1:0] ra, rb;
    int n_done;
    codes  = '{3'b010, 3'b100, 3'b110, 3'b101, 3'b000, 3'b001, 3'b011, 3'b111};
    corner = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

    rst = 1'b1; start = 1'b0; alu_control = 3'b010; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_state", {busy, done, zero, result}, 35'd0);

    run_op("add_7_5",    3'b010, 32'd7, 32'd5, 0);
    run_op("sub_5_5",    3'b100, 32'd5, 32'd5, 0);
    run_op("slt_m3_2",   3'b110, -32'sd3, 32'd2, 0);
    run_op("slt_2_m3",   3'b110, 32'd2, -32'sd3, 0);
    run_op("code000",    3'b000, 32'd3, 32'd4, 0);
    run_op("mul_m6_7",   3'b101, -32'sd6, 32'd7, 0);
    run_op("mul_minneg", 3'b101, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mul_ignore", 3'b101, 32'd12345, -32'sd678, 1);

    // Reset in the middle of a multiply: abort without a done pulse.
    @(negedge clk);
    start = 1'b1; alu_control = 3'b101; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", {busy, done, zero, result}, 35'd0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'd0);
    run_op("add_after_rst", 3'b010, 32'd100, 32'd23, 0);

    // rst and start together: start must be dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; alu_control = 3'b010; src_a = 32'd1; src_b = 32'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_drop", {busy, done, result}, 34'd0);
    @(negedge clk);
    check("rst_start_idle", {busy, done}, 2'd0);

    // Randomized operations, with corner operands mixed in.
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 32'($urandom);
      run_op($sformatf("rnd%0d", i), codes[$urandom_range(0, 7)], ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
